// File: rtl/gfx_pkg.sv
// Shared constants, the fade-state encoding and colour helpers for the
// pixel compositor: background tile indices, lane rows and brightness scaling.
package gfx_pkg;

    // Background palette indices
    localparam logic [5:0] ROAD_IDX  = 6'd8;
    localparam logic [5:0] GRASS_IDX = 6'd21;
    localparam logic [5:0] HUD_IDX   = 6'd63;

    // Tiles are 16x16 pixels, so the tile row is DrawY >> 4
    localparam int TILE_SHIFT = 4;

    // Tile rows holding the two road lanes and the HUD strip
    localparam logic [5:0] LANE_A_FIRST = 6'd10;
    localparam logic [5:0] LANE_A_LAST  = 6'd13;
    localparam logic [5:0] LANE_B_FIRST = 6'd20;
    localparam logic [5:0] LANE_B_LAST  = 6'd23;
    localparam logic [5:0] HUD_LAST_ROW = 6'd1;

    // Brightness limits
    localparam logic [3:0] LEVEL_MAX = 4'd15;
    localparam logic [3:0] LEVEL_MIN = 4'd0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        HOLD     = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    // Palette contents: red, green and blue are overlapping 4-bit windows
    // of the index, which gives index 0 = black and index 63 = white.
    function automatic logic [11:0] palette_entry(input logic [5:0] idx);
        return {idx[5:2], idx[4:1], idx[3:0]};
    endfunction

    // (c * (lvl + 1)) >> 4 ; lvl = 15 is identity, lvl = 0 gives black
    function automatic logic [3:0] scale_channel(input logic [3:0] c,
                                                 input logic [3:0] lvl);
        logic [7:0] prod;
        prod = {4'd0, c} * ({4'd0, lvl} + 8'd1);
        return 4'(prod >> 4);
    endfunction

endpackage

// File: rtl/palette_rom.sv
// 64-entry, 12-bit RGB palette with a registered read port. The output
// register doubles as the colour register of the second pipeline stage.
module palette_rom
    import gfx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  addr,
    output logic [11:0] data
);

    // Synchronous palette read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= 12'd0;
        end else begin
            data <= palette_entry(addr);
        end
    end

endmodule

// File: rtl/pixel_compositor.sv
// Layer compositor for the game display: picks the winning palette index,
// looks it up, applies the fade brightness and keeps syncs aligned with
// colour over a two-stage pipeline. A small FSM runs the fade-out/fade-in.
module pixel_compositor
    import gfx_pkg::*;
(
    input  logic       PixelClk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       Blank,
    input  logic       HSyncIn,
    input  logic       VSyncIn,
    input  logic [5:0] TextPixel,
    input  logic [5:0] P1Pixel,
    input  logic [5:0] P2Pixel,
    input  logic [5:0] MoneyPixel,
    input  logic [5:0] CarPixel,
    input  logic       CarTopHalf,
    input  logic       FadeReq,
    output logic [3:0] Red,
    output logic [3:0] Green,
    output logic [3:0] Blue,
    output logic       HSyncOut,
    output logic       VSyncOut,
    output logic       FadeBusy
);

    logic [5:0]  tile_row_s;
    logic [5:0]  bg_idx_s;
    logic [5:0]  sel_idx_s;
    logic [5:0]  idx_r;
    logic        blank1_r, hs1_r, vs1_r;
    logic        blank2_r, hs2_r, vs2_r;
    logic [11:0] pal_rgb_s;
    logic        vs_prev_r;
    logic        tick_s;
    fade_state_t state_r, state_nx_s;
    logic [3:0]  level_r, level_nx_s;
    logic        fade_busy_r;
    logic        unused_drawx_s;

    // The background depends on the row only; DrawX stays on the interface
    assign unused_drawx_s = ^DrawX;

    assign tile_row_s = 6'(DrawY >> TILE_SHIFT);

    // Background index from the tile row
    always_comb begin
        bg_idx_s = GRASS_IDX;
        if (((tile_row_s >= LANE_A_FIRST) && (tile_row_s <= LANE_A_LAST)) ||
            ((tile_row_s >= LANE_B_FIRST) && (tile_row_s <= LANE_B_LAST))) begin
            bg_idx_s = ROAD_IDX;
        end else if (tile_row_s <= HUD_LAST_ROW) begin
            bg_idx_s = HUD_IDX;
        end else begin
            bg_idx_s = GRASS_IDX;
        end
    end

    // Layer priority: first non-transparent index wins
    always_comb begin
        sel_idx_s = bg_idx_s;
        if (TextPixel != 6'd0) begin
            sel_idx_s = TextPixel;
        end else if (CarTopHalf && (CarPixel != 6'd0)) begin
            sel_idx_s = CarPixel;
        end else if (P1Pixel != 6'd0) begin
            sel_idx_s = P1Pixel;
        end else if (P2Pixel != 6'd0) begin
            sel_idx_s = P2Pixel;
        end else if (MoneyPixel != 6'd0) begin
            sel_idx_s = MoneyPixel;
        end else if (!CarTopHalf && (CarPixel != 6'd0)) begin
            sel_idx_s = CarPixel;
        end else begin
            sel_idx_s = bg_idx_s;
        end
    end

    // Stage 1: selected index plus video timing
    always_ff @(posedge PixelClk or negedge Reset) begin
        if (!Reset) begin
            idx_r    <= 6'd0;
            blank1_r <= 1'b0;
            hs1_r    <= 1'b1;
            vs1_r    <= 1'b1;
        end else begin
            idx_r    <= sel_idx_s;
            blank1_r <= Blank;
            hs1_r    <= HSyncIn;
            vs1_r    <= VSyncIn;
        end
    end

    palette_rom u_palette_rom (
        .clk   (PixelClk),
        .rst_n (Reset),
        .addr  (idx_r),
        .data  (pal_rgb_s)
    );

    // Stage 2: timing delayed alongside the registered palette colour
    always_ff @(posedge PixelClk or negedge Reset) begin
        if (!Reset) begin
            blank2_r <= 1'b0;
            hs2_r    <= 1'b1;
            vs2_r    <= 1'b1;
        end else begin
            blank2_r <= blank1_r;
            hs2_r    <= hs1_r;
            vs2_r    <= vs1_r;
        end
    end

    // Brightness is applied to the stage-2 colour; blanking forces black
    assign Red      = blank2_r ? scale_channel(pal_rgb_s[11:8], level_r) : 4'd0;
    assign Green    = blank2_r ? scale_channel(pal_rgb_s[7:4],  level_r) : 4'd0;
    assign Blue     = blank2_r ? scale_channel(pal_rgb_s[3:0],  level_r) : 4'd0;
    assign HSyncOut = hs2_r;
    assign VSyncOut = vs2_r;
    assign FadeBusy = fade_busy_r;

    // Frame tick on the falling edge of VSyncIn
    assign tick_s = vs_prev_r & ~VSyncIn;

    // Fade next-state and level; the end-point transition happens on the
    // tick that lands on the limit, so a whole fade spans 31 ticks
    always_comb begin
        state_nx_s = state_r;
        level_nx_s = level_r;
        case (state_r)
            IDLE: begin
                if (FadeReq) begin
                    state_nx_s = FADE_OUT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            FADE_OUT: begin
                if (tick_s) begin
                    if (level_r <= 4'd1) begin
                        level_nx_s = LEVEL_MIN;
                        state_nx_s = HOLD;
                    end else begin
                        level_nx_s = level_r - 4'd1;
                    end
                end else begin
                    level_nx_s = level_r;
                end
            end
            HOLD: begin
                if (tick_s) begin
                    state_nx_s = FADE_IN;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            FADE_IN: begin
                if (tick_s) begin
                    if (level_r >= 4'd14) begin
                        level_nx_s = LEVEL_MAX;
                        state_nx_s = IDLE;
                    end else begin
                        level_nx_s = level_r + 4'd1;
                    end
                end else begin
                    level_nx_s = level_r;
                end
            end
            default: begin
                state_nx_s = IDLE;
                level_nx_s = LEVEL_MAX;
            end
        endcase
    end

    // Fade state, level, busy flag and vsync edge register
    always_ff @(posedge PixelClk or negedge Reset) begin
        if (!Reset) begin
            state_r     <= IDLE;
            level_r     <= LEVEL_MAX;
            fade_busy_r <= 1'b0;
            vs_prev_r   <= 1'b1;
        end else begin
            state_r     <= state_nx_s;
            level_r     <= level_nx_s;
            fade_busy_r <= (state_nx_s != IDLE);
            vs_prev_r   <= VSyncIn;
        end
    end

endmodule

// File: tb/tb_pixel_compositor.sv
// Scoreboard bench for pixel_compositor: stimulus pushes expected pixels,
// a monitor pops and compares every cycle; fade level comes from a model
// that counts frame ticks since the fade request.
module tb_pixel_compositor;

    logic       PixelClk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY;
    logic       Blank, HSyncIn, VSyncIn;
    logic [5:0] TextPixel, P1Pixel, P2Pixel, MoneyPixel, CarPixel;
    logic       CarTopHalf, FadeReq;
    logic [3:0] Red, Green, Blue;
    logic       HSyncOut, VSyncOut, FadeBusy;

    pixel_compositor dut (
        .PixelClk(PixelClk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .Blank(Blank), .HSyncIn(HSyncIn), .VSyncIn(VSyncIn),
        .TextPixel(TextPixel), .P1Pixel(P1Pixel), .P2Pixel(P2Pixel),
        .MoneyPixel(MoneyPixel), .CarPixel(CarPixel),
        .CarTopHalf(CarTopHalf), .FadeReq(FadeReq),
        .Red(Red), .Green(Green), .Blue(Blue),
        .HSyncOut(HSyncOut), .VSyncOut(VSyncOut), .FadeBusy(FadeBusy)
    );

    always #20 PixelClk = ~PixelClk;

    typedef struct packed {
        logic [11:0] col;
        logic        blank;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // reference fade model: active flag and ticks counted since the request
    logic m_active;
    int   m_ticks;
    logic m_prev_vs;

    // stimulus-side bookkeeping
    logic last_vs;
    logic drv_tick;
    int   fpos;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int level_of(input logic act, input int t);
        if (!act)   return 15;
        if (t <= 15) return 15 - t;
        if (t == 16) return 0;
        return t - 16;
    endfunction

    function automatic logic [3:0] scl(input logic [3:0] c, input int l);
        int v;
        v = int'(c) * (l + 1) / 16;
        return v[3:0];
    endfunction

    function automatic logic [11:0] ref_color(
        input logic [5:0] t, p1, p2, mo, car, input logic top,
        input logic [9:0] y);
        logic [5:0] order[6];
        int idx, row;
        order = '{t, (top ? car : 6'd0), p1, p2, mo, (top ? 6'd0 : car)};
        idx = -1;
        for (int i = 0; i < 6; i++)
            if (idx < 0 && order[i] != 6'd0) idx = int'(order[i]);
        if (idx < 0) begin
            row = int'(y) / 16;
            if ((row >= 10 && row <= 13) || (row >= 20 && row <= 23)) idx = 8;
            else if (row < 2) idx = 63;
            else idx = 21;
        end
        return {4'(idx / 4), 4'((idx / 2) % 16), 4'(idx % 16)};
    endfunction

    // drive one pixel's inputs (caller is at a negedge) and record expectation
    task automatic put(input logic [5:0] t, p1, p2, mo, car, input logic top,
                       input logic [9:0] y, input logic blk, hs, vs, req);
        exp_t e;
        TextPixel = t; P1Pixel = p1; P2Pixel = p2; MoneyPixel = mo;
        CarPixel = car; CarTopHalf = top; DrawY = y;
        DrawX = 10'($urandom_range(0, 639));
        Blank = blk; HSyncIn = hs; VSyncIn = vs; FadeReq = req;
        drv_tick = last_vs && !vs;
        last_vs = vs;
        e.col = ref_color(t, p1, p2, mo, car, top, y);
        e.blank = blk; e.hs = hs; e.vs = vs;
        sb_q.push_back(e);
    endtask

    function automatic logic [5:0] rnd_layer();
        if ($urandom_range(0, 1) == 0) return 6'd0;
        return 6'($urandom_range(1, 63));
    endfunction

    task automatic rnd_pixel(input logic vs, input logic req);
        put(rnd_layer(), rnd_layer(), rnd_layer(), rnd_layer(), rnd_layer(),
            1'($urandom_range(0, 1)), 10'($urandom_range(0, 479)),
            1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), vs, req);
    endtask

    // frames of 8 pixels, vsync low for the first two
    task automatic frame_pixel(input logic req);
        logic vs;
        vs = ((fpos % 8) >= 2);
        fpos++;
        rnd_pixel(vs, req);
    endtask

    // reference fade model, advanced on the same edges as the DUT
    always @(posedge PixelClk or negedge Reset) begin
        if (!Reset) begin
            m_active  <= 1'b0;
            m_ticks   <= 0;
            m_prev_vs <= 1'b1;
        end else begin
            m_prev_vs <= VSyncIn;
            if (!m_active) begin
                if (FadeReq) begin
                    m_active <= 1'b1;
                    m_ticks  <= 0;
                end
            end else if (m_prev_vs && !VSyncIn) begin
                if (m_ticks == 30) begin
                    m_active <= 1'b0;
                    m_ticks  <= 0;
                end else begin
                    m_ticks <= m_ticks + 1;
                end
            end
        end
    end

    exp_t        mon_e;
    int          mon_lvl;
    logic [11:0] mon_rgb;

    // monitor: output after edge m belongs to the pixel captured at edge m-1
    always @(posedge PixelClk) begin
        #1;
        if (Reset === 1'b1 && sb_q.size() >= 2) begin
            mon_e   = sb_q.pop_front();
            mon_lvl = level_of(m_active, m_ticks);
            mon_rgb = 12'd0;
            if (mon_e.blank)
                mon_rgb = {scl(mon_e.col[11:8], mon_lvl),
                           scl(mon_e.col[7:4], mon_lvl),
                           scl(mon_e.col[3:0], mon_lvl)};
            check("rgb", {20'd0, Red, Green, Blue}, {20'd0, mon_rgb});
            check("hsync_out", {31'd0, HSyncOut}, {31'd0, mon_e.hs});
            check("vsync_out", {31'd0, VSyncOut}, {31'd0, mon_e.vs});
            check("fade_busy", {31'd0, FadeBusy}, {31'd0, m_active});
        end
    end

    initial begin
        int  ticks;
        logic req_done, found;

        Reset = 1'b0;
        TextPixel = 6'd0; P1Pixel = 6'd0; P2Pixel = 6'd0; MoneyPixel = 6'd0;
        CarPixel = 6'd0; CarTopHalf = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
        Blank = 1'b0; HSyncIn = 1'b1; VSyncIn = 1'b1; FadeReq = 1'b0;
        last_vs = 1'b1; fpos = 0; drv_tick = 1'b0;

        #30;
        check("reset_rgb", {20'd0, Red, Green, Blue}, 32'd0);
        check("reset_hsync", {31'd0, HSyncOut}, 32'd1);
        check("reset_vsync", {31'd0, VSyncOut}, 32'd1);
        check("reset_busy", {31'd0, FadeBusy}, 32'd0);

        // directed pixels: priority, background rows, blanking, syncs
        @(negedge PixelClk);
        Reset = 1'b1;
        put(6'd0, 6'h05, 6'd0, 6'd0, 6'h09, 1'b1, 10'd100, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge PixelClk);
        put(6'd0, 6'h05, 6'd0, 6'd0, 6'h09, 1'b0, 10'd100, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge PixelClk);
        put(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 10'd170, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge PixelClk);
        put(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 10'd100, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge PixelClk);
        put(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 10'd170, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge PixelClk);
        put(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 10'd16, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge PixelClk);
        put(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 10'd330, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge PixelClk);
        put(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 10'd383, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge PixelClk);
        put(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 10'd384, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge PixelClk);
        put(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 10'd159, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge PixelClk);
        put(6'h11, 6'h05, 6'h06, 6'h07, 6'h09, 1'b1, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge PixelClk);
        put(6'd0, 6'd0, 6'h06, 6'h07, 6'h09, 1'b0, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge PixelClk);
        put(6'd0, 6'd0, 6'd0, 6'h07, 6'h09, 1'b0, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0);

        // random pixels, no frame ticks
        for (int i = 0; i < 60; i++) begin
            @(negedge PixelClk);
            rnd_pixel(1'b1, 1'b0);
        end

        // full fade with an ignored second request during fade-in
        for (int i = 0; i < 5; i++) begin
            @(negedge PixelClk);
            frame_pixel(1'b0);
        end
        @(negedge PixelClk);
        frame_pixel(1'b1);
        ticks = 0;
        req_done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge PixelClk);
            if (i == 0) check("busy_after_req", {31'd0, FadeBusy}, 32'd1);
            if (!FadeBusy) break;
            if (m_active && m_ticks == 20 && !req_done) begin
                req_done = 1'b1;
                fpos++;
                put(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 10'd8, 1'b1, 1'b1,
                    ((fpos - 1) % 8) >= 2, 1'b1);
            end else if (level_of(m_active, m_ticks) == 7) begin
                fpos++;
                put(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 10'd8, 1'b1, 1'b1,
                    ((fpos - 1) % 8) >= 2, 1'b0);
            end else begin
                frame_pixel(1'b0);
            end
            if (drv_tick) ticks++;
        end
        check("fade_tick_count", ticks, 32'd31);
        check("fade_done_busy", {31'd0, FadeBusy}, 32'd0);

        // second fade, reset applied at level 6 during fade-out
        @(negedge PixelClk);
        frame_pixel(1'b1);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge PixelClk);
            if (m_active && m_ticks == 9) begin
                found = 1'b1;
                break;
            end
            frame_pixel(1'b0);
        end
        check("reached_level6", {31'd0, found}, 32'd1);
        HSyncIn = 1'b0; VSyncIn = 1'b0;
        #5;
        Reset = 1'b0;
        sb_q.delete();
        #1;
        check("midfade_reset_rgb", {20'd0, Red, Green, Blue}, 32'd0);
        check("midfade_reset_hsync", {31'd0, HSyncOut}, 32'd1);
        check("midfade_reset_vsync", {31'd0, VSyncOut}, 32'd1);
        check("midfade_reset_busy", {31'd0, FadeBusy}, 32'd0);
        repeat (2) @(negedge PixelClk);
        Reset = 1'b1;
        last_vs = 1'b1;
        fpos = 0;
        frame_pixel(1'b0);
        for (int i = 0; i < 80; i++) begin
            @(negedge PixelClk);
            frame_pixel(1'b0);
        end

        // mixed traffic with occasional fade requests in any state
        for (int i = 0; i < 600; i++) begin
            @(negedge PixelClk);
            frame_pixel($urandom_range(0, 40) == 0);
        end

        @(negedge PixelClk);
        frame_pixel(1'b0);
        repeat (3) @(posedge PixelClk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pixel_compositor.md
PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

Interface
REQ-001 PixelClk  in  1  pixel clock (25 MHz); the only clock; all state updates on its rising edge.
REQ-002 Reset  in  1  asynchronous, active-low reset.
REQ-003 DrawX, DrawY  in  10 each  current pixel coordinate from the VGA controller.
REQ-004 Blank  in  1  1 = active video, 0 = blanking.
REQ-005 HSyncIn, VSyncIn  in  1 each  active-low syncs from the VGA controller.
REQ-006 TextPixel, P1Pixel, P2Pixel, MoneyPixel, CarPixel  in  6 each  palette indices from game; 0 = transparent.
REQ-007 CarTopHalf  in  1  current CarPixel belongs to a car's upper half.
REQ-008 FadeReq  in  1  single-cycle request for a fade-out/fade-in transition.
REQ-009 Red, Green, Blue  out  4 each  final colour.
REQ-010 HSyncOut, VSyncOut  out  1 each  syncs delayed to align with the colour outputs.
REQ-011 FadeBusy  out  1  high while a fade is in progress.

Function
REQ-012 Layer priority, highest first:
- Text
- car (CarTopHalf=1)
- P1
- P2
- Money
- car (CarTopHalf=0)
- background
The first non-zero index wins.
REQ-013 Background index:
- Tile row = DrawY[9:4].
- Rows 10-13 and 20-23 select ROAD_IDX.
- Rows 0-1 select HUD_IDX.
- All other rows select GRASS_IDX.
REQ-014 Stage 1 registers the selected 6-bit index, Blank, HSyncIn and VSyncIn.
REQ-015 Stage 2 performs the palette lookup (synchronous read) and registers the scaled RGB, delayed Blank and syncs.
REQ-016 Total latency is exactly 2 PixelClk cycles for colour and syncs; no bubbles; one pixel is accepted every cycle.
REQ-017 When delayed Blank=0, Red/Green/Blue are forced to 0 regardless of index.
REQ-018 Brightness level L is 4 bits, range 0..15.
REQ-019 Each output channel = (c * (L+1)) >> 4, where c is the 4-bit palette channel; L=15 passes c unchanged and L=0 yields c>>4 = 0.
REQ-020 A frame tick is a 1-cycle pulse on each falling edge of VSyncIn, detected with a registered copy of VSyncIn.
REQ-021 Fade FSM has states IDLE, FADE_OUT, HOLD, FADE_IN.
- IDLE: FadeReq=1 -> FADE_OUT.
- FADE_OUT: L decrements by 1 per frame tick; at a tick with L=0 -> HOLD.
- HOLD: the next frame tick -> FADE_IN.
- FADE_IN: L increments by 1 per tick; at a tick with L=15 -> IDLE.
REQ-022 FadeReq is ignored in any state other than IDLE.
REQ-023 FadeReq coincident with a frame tick in IDLE enters FADE_OUT; the first decrement occurs at the following tick.
REQ-024 L never wraps; it saturates at 0 and 15.
REQ-025 FadeBusy = (state != IDLE), driven from a register.
REQ-026 L changes only on frame ticks, never mid-frame.

Reset
REQ-027 On Reset=0, asynchronously:
- Red, Green, Blue = 0.
- HSyncOut = VSyncOut = 1.
- Pipeline index registers = 0; pipeline Blank registers = 0.
- L = 15; state = IDLE; FadeBusy = 0.
- Vsync edge register = 1.
REQ-028 Reset asserted mid-fade abandons the fade; after release, output is at full brightness with no residual tick.

Structure
REQ-029 Package gfx_pkg holds:
- ROAD_IDX, GRASS_IDX, HUD_IDX, TILE_SHIFT=4.
- Lane row constants 10-13 and 20-23.
- The fade-state enum.
REQ-030 Sub-module palette_rom: 64x12-bit ROM with registered read output. It is the only sub-module; the priority mux, scaler and FSM live in pixel_compositor.

Verification
REQ-031 P1Pixel=0x05, CarPixel=0x09, CarTopHalf=1, Blank=1 -> output colour = palette[0x09] 2 cycles later; with CarTopHalf=0 -> palette[0x05].
REQ-032 All layers 0, DrawY=170 (row 10) -> palette[ROAD_IDX]; DrawY=100 (row 6) -> palette[GRASS_IDX]; Blank=0 -> RGB 0.
REQ-033 Toggle HSyncIn/VSyncIn at a known cycle -> HSyncOut/VSyncOut follow exactly 2 cycles later.
REQ-034 FadeReq pulse in IDLE -> FadeBusy=1 the next cycle; L reaches 0 after 15 frame ticks; HOLD lasts 1 tick; L returns to 15 after 15 more ticks; FadeBusy=0 after 31 ticks total.
REQ-035 Palette colour 0xFFF at L=7 -> RGB = 0x777; second FadeReq during FADE_IN -> ignored, tick count unchanged.
REQ-036 Reset=0 asserted at L=6 in FADE_OUT -> immediately RGB=0, L=15, IDLE; first frame after release is at full brightness.
